// File: rtl/onehot_pulse_decoder.sv
// Sequential index-to-one-hot pulse expander.
// FIFO-buffered indices replayed as pulses of programmable length.
module onehot_pulse_decoder #(
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int LENW  = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDXW-1:0]  in_idx,
  input  logic [LENW-1:0]  in_len,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy,
  output logic             err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP
  } state_t;

  logic [IDXW-1:0]  mem_idx [DEPTH];
  logic [LENW-1:0]  mem_len [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;
  logic             head_ok;
  logic             drop;
  logic             drop_q;
  state_t           state;
  state_t           state_next;
  logic [LENW-1:0]  cnt;
  logic [LENW-1:0]  cnt_next;
  logic [WIDTH-1:0] drive;
  logic [WIDTH-1:0] drive_next;

  assign push       = in_valid && in_ready;
  assign head_ok    = int'(mem_idx[rd_ptr]) < WIDTH;
  assign count_next = count + CW'(push) - CW'(pop);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    drive_next = drive;
    pop        = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE, GAP: begin
        drive_next = '0;
        state_next = IDLE;
        if (count != '0) begin
          pop = 1'b1;
          if (head_ok) begin
            drive_next = WIDTH'(1) << mem_idx[rd_ptr];
            cnt_next   = mem_len[rd_ptr];
            state_next = DRIVE;
          end else begin
            drop       = 1'b1;
            state_next = GAP;
          end
        end
      end
      DRIVE: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          drive_next = '0;
          state_next = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wr_ptr] <= in_idx;
      mem_len[wr_ptr] <= in_len;
    end
  end

  // out/err sit one register behind the FSM so every pulse
  // shares the same two-stage latency from acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      drive     <= '0;
      drop_q    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      count     <= count_next;
      in_ready  <= count_next < FULL;
      state     <= state_next;
      cnt       <= cnt_next;
      drive     <= drive_next;
      drop_q    <= drop;
      out       <= drive;
      out_valid <= |drive;
      err       <= drop_q;
      busy      <= (count != '0) || (state != IDLE);
    end
  end

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder.
// Default instance plus a WIDTH=6 instance for dropped indices.
module tb_onehot_pulse_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_valid = 1'b0;
  logic       a_ready;
  logic [2:0] a_idx = '0;
  logic [3:0] a_len = '0;
  logic [7:0] a_out;
  logic       a_ov;
  logic       a_busy;
  logic       a_err;

  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [2:0] b_idx = '0;
  logic [3:0] b_len = '0;
  logic [5:0] b_out;
  logic       b_ov;
  logic       b_busy;
  logic       b_err;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [2:0] idx;
    logic [3:0] len;
    logic [7:0] exp_out;
    int         exp_cyc;
  } vec_t;

  vec_t vt[6];

  logic       rec = 1'b0;
  logic [7:0] trace[$];
  int         run_len[$];
  int         gap_len[$];

  always #5 clk = ~clk;

  always @(negedge clk) if (rec) trace.push_back(a_out);

  onehot_pulse_decoder dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .in_idx   (a_idx),
    .in_len   (a_len),
    .out      (a_out),
    .out_valid(a_ov),
    .busy     (a_busy),
    .err      (a_err)
  );

  onehot_pulse_decoder #(.WIDTH(6)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .in_idx   (b_idx),
    .in_len   (b_len),
    .out      (b_out),
    .out_valid(b_ov),
    .busy     (b_busy),
    .err      (b_err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (a_busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("busy_idle", 32'(a_busy), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_b2b[6];
    logic [5:0] exp_bo[4];
    logic       exp_be[4];
    int acc;
    int cur;
    int zr;
    int badv;
    logic inrun;
    logic seen_full;

    vt[0] = '{3'd5, 4'd2,  8'h20, 3};
    vt[1] = '{3'd0, 4'd0,  8'h01, 1};
    vt[2] = '{3'd7, 4'd15, 8'h80, 16};
    vt[3] = '{3'd3, 4'd4,  8'h08, 5};
    vt[4] = '{3'd6, 4'd1,  8'h40, 2};
    vt[5] = '{3'd1, 4'd7,  8'h02, 8};

    // reset
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(a_out), 32'd0);
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready_a", 32'(a_ready), 32'd1);
    chk("rel_ready_b", 32'(b_ready), 32'd1);

    // table-driven single pulses
    foreach (vt[v]) begin
      @(negedge clk);
      chk("vec_ready", 32'(a_ready), 32'd1);
      a_valid = 1'b1;
      a_idx   = vt[v].idx;
      a_len   = vt[v].len;
      @(negedge clk);
      a_valid = 1'b0;
      chk("vec_k", 32'(a_out), 32'd0);
      @(negedge clk);
      chk("vec_k1", 32'(a_out), 32'd0);
      for (int c = 0; c < vt[v].exp_cyc; c++) begin
        @(negedge clk);
        chk("vec_out", 32'(a_out), 32'(vt[v].exp_out));
        chk("vec_ov", 32'(a_ov), 32'd1);
        chk("vec_err", 32'(a_err), 32'd0);
      end
      @(negedge clk);
      chk("vec_end", 32'(a_out), 32'd0);
      chk("vec_ov0", 32'(a_ov), 32'd0);
      wait_idle();
    end

    // back-to-back
    exp_b2b = '{8'h00, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00};
    @(negedge clk);
    a_valid = 1'b1;
    a_idx = 3'd0;
    a_len = 4'd0;
    @(negedge clk);
    a_idx = 3'd7;
    a_len = 4'd1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("b2b_out", 32'(a_out), 32'(exp_b2b[i]));
    end
    wait_idle();

    // backpressure: exactly 4 accepts, ready drops after 3
    @(negedge clk);
    trace.delete();
    rec = 1'b1;
    a_valid = 1'b1;
    a_idx = 3'd3;
    a_len = 4'd15;
    acc = 0;
    seen_full = 1'b0;
    for (int g = 0; g < 200 && acc < 4; g++) begin
      if (a_ready) acc++;
      @(posedge clk);
      #1;
      if (acc == 3 && !seen_full) begin
        seen_full = 1'b1;
        chk("full_ready", 32'(a_ready), 32'd0);
      end
    end
    a_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd4);
    repeat (80) @(negedge clk);
    rec = 1'b0;
    run_len.delete();
    gap_len.delete();
    inrun = 1'b0;
    cur = 0;
    zr = 0;
    badv = 0;
    foreach (trace[i]) begin
      if (trace[i] != 8'h00) begin
        if (!inrun) begin
          if (run_len.size() > 0) gap_len.push_back(zr);
          inrun = 1'b1;
          cur = 0;
        end
        cur++;
        if (trace[i] != 8'h08) badv++;
      end else begin
        if (inrun) begin
          run_len.push_back(cur);
          inrun = 1'b0;
          zr = 0;
        end
        zr++;
      end
    end
    chk("bp_runs", 32'(run_len.size()), 32'd4);
    chk("bp_open", 32'(inrun), 32'd0);
    chk("bp_value", 32'(badv), 32'd0);
    foreach (run_len[i]) chk("bp_width", 32'(run_len[i]), 32'd16);
    foreach (gap_len[i]) chk("bp_gap", 32'(gap_len[i]), 32'd1);
    wait_idle();

    // dropped index on the narrow instance
    exp_bo = '{6'h00, 6'h00, 6'h02, 6'h00};
    exp_be = '{1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    b_valid = 1'b1;
    b_idx = 3'd6;
    b_len = 4'd0;
    @(negedge clk);
    b_idx = 3'd1;
    b_len = 4'd0;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("inv_out", 32'(b_out), 32'(exp_bo[i]));
      chk("inv_err", 32'(b_err), 32'(exp_be[i]));
    end

    // reset mid-pulse with two entries queued
    @(negedge clk);
    a_valid = 1'b1;
    a_idx = 3'd4;
    a_len = 4'd7;
    @(negedge clk);
    a_idx = 3'd1;
    a_len = 4'd3;
    @(negedge clk);
    a_idx = 3'd2;
    a_len = 4'd3;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    chk("mid_pulse", 32'(a_out), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(a_out), 32'd0);
    chk("mid_rst_ov", 32'(a_ov), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_out", 32'(a_out), 32'd0);
      chk("post_busy", 32'(a_busy), 32'd0);
    end
    chk("post_ready", 32'(a_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
